// File: rtl/gcd_dispatch_pkg.sv
// Shared types and helpers for the GCD job dispatcher: core state, job and
// completion records, and a lowest-set-bit priority encoder.
package gcd_dispatch_pkg;

    localparam int unsigned MAX_CORES    = 8;
    localparam int unsigned CORE_IDX_W   = 3;
    localparam int unsigned DEF_OPCODE_W = 12;
    localparam int unsigned DEF_SLOT_W   = 4;
    localparam int unsigned DEF_CYCLE_W  = 12;
    localparam int unsigned DEF_TIMEOUT  = 4095;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } core_state_t;

    typedef struct packed {
        logic [DEF_OPCODE_W-1:0] opcode;
        logic                    ct;
        logic [DEF_SLOT_W-1:0]   slot;
    } job_t;

    typedef struct packed {
        logic [CORE_IDX_W-1:0]  core;
        logic [DEF_SLOT_W-1:0]  slot;
        logic [DEF_CYCLE_W-1:0] cycles;
        logic                   timeout;
    } cmp_t;

    // Index of the lowest set bit; 0 when none is set.
    function automatic logic [CORE_IDX_W-1:0] lowest_set(input logic [MAX_CORES-1:0] v);
        lowest_set = '0;
        for (int i = MAX_CORES - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CORE_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/gcd_job_fifo.sv
// Synchronous job FIFO with enable-qualified push/pop. Pointers carry an
// extra wrap bit so full and empty are distinguishable.
module gcd_job_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 17
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = en && push && !full;
    assign do_pop  = en && pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

endmodule

// File: rtl/gcd_job_dispatcher.sv
// Job front-end for a pool of GCD cores: queues requests, dispatches to the
// lowest idle core, times each job and returns completion records with an IRQ.
module gcd_job_dispatcher
    import gcd_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter int unsigned OPCODE_W    = 12,
    parameter int unsigned SLOT_W      = 4,
    parameter int unsigned CYCLE_W     = 12,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          CLKEN,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [OPCODE_W-1:0]           job_opcode,
    input  logic                          job_ct,
    input  logic [SLOT_W-1:0]             job_slot,
    output logic [NUM_CORES-1:0]          core_start,
    output logic [NUM_CORES*OPCODE_W-1:0] core_opcode,
    output logic [NUM_CORES-1:0]          core_ct,
    output logic [NUM_CORES*SLOT_W-1:0]   core_slot,
    input  logic [NUM_CORES-1:0]          core_done,
    output logic                          cmp_valid,
    input  logic                          cmp_ready,
    output logic [2:0]                    cmp_core,
    output logic [SLOT_W-1:0]             cmp_slot,
    output logic [CYCLE_W-1:0]            cmp_cycles,
    output logic                          cmp_timeout,
    input  logic                          irq_en,
    output logic                          irq,
    output logic                          busy
);

    localparam int unsigned JOB_W = OPCODE_W + 1 + SLOT_W;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH) + 1;

    logic [JOB_W-1:0]             head_job;
    logic [OPCODE_W-1:0]          head_opcode;
    logic                         head_ct;
    logic [SLOT_W-1:0]            head_slot;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [CNT_W-1:0]             fifo_count;
    logic [NUM_CORES-1:0]         idle_vec;
    logic [NUM_CORES-1:0]         hold_vec;
    logic [NUM_CORES-1:0]         timeout_vec;
    logic [NUM_CORES*CYCLE_W-1:0] cycles_flat;
    logic [CORE_IDX_W-1:0]        disp_idx;
    logic [CORE_IDX_W-1:0]        hold_idx;
    logic [CORE_IDX_W-1:0]        cmp_idx;
    logic [CORE_IDX_W-1:0]        lock_idx;
    logic                         lock_valid;
    logic                         dispatch;
    logic                         accept;

    gcd_job_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .en    (CLKEN),
        .push  (job_valid),
        .pop   (dispatch),
        .wdata ({job_opcode, job_ct, job_slot}),
        .rdata (head_job),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign head_opcode = head_job[JOB_W-1 -: OPCODE_W];
    assign head_ct     = head_job[SLOT_W];
    assign head_slot   = head_job[SLOT_W-1:0];

    assign job_ready = !fifo_full;
    assign busy      = (fifo_count != '0) || !(&idle_vec);
    assign dispatch  = CLKEN && !fifo_empty && (|idle_vec);
    assign disp_idx  = lowest_set(MAX_CORES'(idle_vec));
    assign hold_idx  = lowest_set(MAX_CORES'(hold_vec));

    // A presented record stays locked until accepted, even if a lower core finishes.
    assign cmp_valid = |hold_vec;
    assign cmp_idx   = lock_valid ? lock_idx : hold_idx;
    assign cmp_core  = cmp_valid ? cmp_idx : '0;
    assign accept    = CLKEN && cmp_valid && cmp_ready;

    always_comb begin
        cmp_slot    = '0;
        cmp_cycles  = '0;
        cmp_timeout = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cmp_valid && cmp_idx == CORE_IDX_W'(i)) begin
                cmp_slot    = core_slot[i*SLOT_W +: SLOT_W];
                cmp_cycles  = cycles_flat[i*CYCLE_W +: CYCLE_W];
                cmp_timeout = timeout_vec[i];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lock_valid <= 1'b0;
            lock_idx   <= '0;
            irq        <= 1'b0;
        end else if (CLKEN) begin
            lock_valid <= cmp_valid && !cmp_ready;
            lock_idx   <= cmp_idx;
            irq        <= irq_en && cmp_valid;
        end
    end

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        core_state_t         state;
        logic [CYCLE_W-1:0]  cnt;
        logic [CYCLE_W-1:0]  cnt_inc;
        logic                done_r;
        logic                tmo;
        logic                start;
        logic                ct;
        logic [OPCODE_W-1:0] opc;
        logic [SLOT_W-1:0]   slot;
        logic                go;
        logic                rise;
        logic                release_core;

        assign cnt_inc      = cnt + CYCLE_W'(1);
        assign go           = dispatch && (disp_idx == CORE_IDX_W'(i));
        assign rise         = core_done[i] && !done_r;
        assign release_core = accept && (cmp_idx == CORE_IDX_W'(i));

        // Per-core lifecycle: IDLE -> RUN on dispatch, RUN -> HOLD on done/timeout,
        // HOLD -> IDLE once the completion record is taken.
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                state  <= IDLE;
                cnt    <= '0;
                done_r <= 1'b0;
                tmo    <= 1'b0;
                start  <= 1'b0;
                ct     <= 1'b0;
                opc    <= '0;
                slot   <= '0;
            end else if (CLKEN) begin
                done_r <= core_done[i];
                start  <= 1'b0;
                case (state)
                    IDLE: begin
                        if (go) begin
                            state <= RUN;
                            start <= 1'b1;
                            cnt   <= '0;
                            tmo   <= 1'b0;
                            opc   <= head_opcode;
                            ct    <= head_ct;
                            slot  <= head_slot;
                        end
                    end
                    RUN: begin
                        cnt <= cnt_inc;
                        if (rise) begin
                            state <= HOLD;
                            tmo   <= 1'b0;
                        end else if (cnt_inc == CYCLE_W'(TIMEOUT)) begin
                            state <= HOLD;
                            tmo   <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (release_core) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign core_start[i]                     = start;
        assign core_ct[i]                        = ct;
        assign core_opcode[i*OPCODE_W +: OPCODE_W] = opc;
        assign core_slot[i*SLOT_W +: SLOT_W]     = slot;
        assign cycles_flat[i*CYCLE_W +: CYCLE_W] = cnt;
        assign timeout_vec[i]                    = tmo;
        assign idle_vec[i]                       = (state == IDLE);
        assign hold_vec[i]                       = (state == HOLD);
    end

endmodule

// File: tb/tb_gcd_job_dispatcher.sv
// Scoreboard bench for gcd_job_dispatcher: directed jobs push expected
// completion records; a negedge monitor pops and compares on each handshake.
module tb_gcd_job_dispatcher;
    import gcd_dispatch_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CLKEN;
    logic        job_valid;
    logic        job_ready;
    logic [11:0] job_opcode;
    logic        job_ct;
    logic [3:0]  job_slot;
    logic [1:0]  core_start;
    logic [23:0] core_opcode;
    logic [1:0]  core_ct;
    logic [7:0]  core_slot;
    logic [1:0]  core_done;
    logic        cmp_valid;
    logic        cmp_ready;
    logic [2:0]  cmp_core;
    logic [3:0]  cmp_slot;
    logic [11:0] cmp_cycles;
    logic        cmp_timeout;
    logic        irq_en;
    logic        irq;
    logic        busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    cmp_t exp_q[$];

    gcd_job_dispatcher dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .CLKEN       (CLKEN),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_opcode  (job_opcode),
        .job_ct      (job_ct),
        .job_slot    (job_slot),
        .core_start  (core_start),
        .core_opcode (core_opcode),
        .core_ct     (core_ct),
        .core_slot   (core_slot),
        .core_done   (core_done),
        .cmp_valid   (cmp_valid),
        .cmp_ready   (cmp_ready),
        .cmp_core    (cmp_core),
        .cmp_slot    (cmp_slot),
        .cmp_cycles  (cmp_cycles),
        .cmp_timeout (cmp_timeout),
        .irq_en      (irq_en),
        .irq         (irq),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Completion monitor: every accepted record must match the head of the queue.
    always @(negedge CLK) begin
        if (!RESET && CLKEN && cmp_valid && cmp_ready) begin
            cmp_t got;
            cmp_t exp;
            got = '{core: cmp_core, slot: cmp_slot, cycles: cmp_cycles, timeout: cmp_timeout};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_cmp: got 0x%0h expected none", got);
            end else begin
                exp = exp_q.pop_front();
                check("cmp_record", 32'(got), 32'(exp));
            end
        end
    end

    task automatic next();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_cmp(input int core, input int slot, input int cyc, input bit tmo);
        exp_q.push_back('{core: 3'(core), slot: 4'(slot), cycles: 12'(cyc), timeout: tmo});
    endtask

    task automatic drive_job(input job_t j);
        job_valid  = 1'b1;
        job_opcode = j.opcode;
        job_ct     = j.ct;
        job_slot   = j.slot;
    endtask

    // Returns at the negedge of the cycle in which core_start[c] is seen.
    task automatic wait_start(input int c, input int budget, output int waited);
        bit found = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            @(negedge CLK);
            waited++;
            if (core_start[c]) found = 1'b1;
        end
        if (!found) check($sformatf("start_timeout_core%0d", c), 32'(0), 32'(1));
    endtask

    // Called at the negedge of the start cycle; done is seen k cycles in.
    task automatic done_after(input int c, input int k);
        repeat (k - 1) @(posedge CLK);
        #1 core_done[c] = 1'b1;
        @(posedge CLK);
        #1 core_done[c] = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || cmp_valid) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'(0));
    endtask

    initial begin
        int w;
        RESET      = 1'b1;
        CLKEN      = 1'b1;
        job_valid  = 1'b0;
        job_opcode = '0;
        job_ct     = 1'b0;
        job_slot   = '0;
        core_done  = '0;
        cmp_ready  = 1'b1;
        irq_en     = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst_job_ready", 32'(job_ready), 32'(1));
        check("rst_cmp_valid", 32'(cmp_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_core_start", 32'(core_start), 32'(0));
        check("rst_irq", 32'(irq), 32'(0));
        check("rst_cmp_cycles", 32'(cmp_cycles), 32'(0));

        // Single job: start at t+2, done seen on the 10th cycle, irq a cycle later
        next();
        drive_job('{opcode: 12'h005, ct: 1'b1, slot: 4'd3});
        next();
        job_valid = 1'b0;
        @(negedge CLK);
        check("s1_no_bypass", 32'(core_start), 32'(0));
        next();
        @(negedge CLK);
        check("s1_start", 32'(core_start), 32'b01);
        check("s1_opcode", 32'(core_opcode[11:0]), 32'h005);
        check("s1_slot_ct", 32'({core_slot[3:0], core_ct[0]}), 32'({4'd3, 1'b1}));
        expect_cmp(0, 3, 10, 1'b0);
        done_after(0, 10);
        @(negedge CLK);
        check("s1_cmp_valid", 32'(cmp_valid), 32'(1));
        check("s1_irq_delay", 32'(irq), 32'(0));
        next();
        @(negedge CLK);
        check("s1_irq", 32'(irq), 32'(1));
        check("s1_cmp_done", 32'(cmp_valid), 32'(0));
        wait_drain(20);

        // Core 1 finishes first; record held while cmp_ready is low
        next();
        cmp_ready = 1'b0;
        drive_job('{opcode: 12'h0A1, ct: 1'b0, slot: 4'd1});
        next();
        drive_job('{opcode: 12'h0B2, ct: 1'b0, slot: 4'd2});
        next();
        job_valid = 1'b0;
        wait_start(0, 10, w);
        expect_cmp(1, 2, 4, 1'b0);
        expect_cmp(0, 1, 8, 1'b0);
        expect_cmp(1, 5, 3, 1'b0);
        repeat (4) @(posedge CLK);
        #1 core_done[1] = 1'b1;
        next();
        core_done[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next();
            if (i == 0) drive_job('{opcode: 12'h0C3, ct: 1'b0, slot: 4'd5});
            else job_valid = 1'b0;
            core_done[0] = (i == 2);
            @(negedge CLK);
            check($sformatf("s3_hold_stable_%0d", i),
                  32'({cmp_valid, cmp_core, cmp_slot, cmp_cycles, core_start}),
                  32'({1'b1, 3'd1, 4'd2, 12'd4, 2'b00}));
        end
        next();
        cmp_ready = 1'b1;
        wait_start(1, 10, w);
        check("s3_redispatch_lat", 32'(w), 32'(3));
        done_after(1, 3);
        wait_drain(20);

        // CLKEN toggling: only odd (enabled) cycles push, pop, start or count
        expect_cmp(0, 7, 8, 1'b0);
        for (int c = 0; c < 30; c++) begin
            next();
            CLKEN        = c[0];
            job_valid    = (c == 2 || c == 3);
            job_opcode   = 12'h0AB;
            job_ct       = 1'b0;
            job_slot     = 4'd7;
            core_done[0] = (c >= 20 && c <= 24);
            @(negedge CLK);
            case (c)
                3:  check("s5_no_push_disabled", 32'(busy), 32'(0));
                5:  check("s5_no_pop_disabled", 32'(core_start), 32'(0));
                6:  check("s5_start_hold", 32'(core_start), 32'b01);
                7:  check("s5_start_enabled", 32'(core_start), 32'b01);
                8:  check("s5_start_cleared", 32'(core_start), 32'(0));
                22: check("s5_cmp_valid", 32'(cmp_valid), 32'(1));
                default: ;
            endcase
        end
        next();
        CLKEN = 1'b1;
        job_valid = 1'b0;
        wait_drain(20);

        // Reset while both cores run and two jobs wait: silent abort
        next();
        for (int i = 0; i < 4; i++) begin
            drive_job('{opcode: 12'(16 + i), ct: 1'b0, slot: 4'(i)});
            next();
        end
        job_valid = 1'b0;
        @(negedge CLK);
        check("s6_pre_busy", 32'({busy, job_ready}), 32'({1'b1, 1'b1}));
        next();
        RESET = 1'b1;
        next();
        RESET = 1'b0;
        @(negedge CLK);
        check("s6_busy", 32'(busy), 32'(0));
        check("s6_cmp_valid", 32'(cmp_valid), 32'(0));
        check("s6_job_ready", 32'(job_ready), 32'(1));
        next();
        drive_job('{opcode: 12'h009, ct: 1'b0, slot: 4'd9});
        next();
        job_valid = 1'b0;
        expect_cmp(0, 9, 5, 1'b0);
        wait_start(0, 10, w);
        check("s6_lat", 32'(w), 32'(2));
        done_after(0, 5);
        wait_drain(20);

        // Done edge and timeout in the same cycle: done wins
        next();
        drive_job('{opcode: 12'h044, ct: 1'b0, slot: 4'd6});
        next();
        job_valid = 1'b0;
        expect_cmp(0, 6, 4095, 1'b0);
        wait_start(0, 10, w);
        done_after(0, 4095);
        wait_drain(20);

        // Spurious done on an idle core produces nothing
        next();
        core_done[1] = 1'b1;
        next();
        core_done[1] = 1'b0;
        repeat (3) @(negedge CLK);
        check("s4_spurious", 32'({cmp_valid, busy, core_start}), 32'(0));

        // Six jobs, no done: queue fills, all time out, FIFO order kept
        next();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("s2_ready_%0d", i), 32'(job_ready), 32'(1));
            drive_job('{opcode: 12'(32 + i), ct: 1'b0, slot: 4'(8 + i)});
            expect_cmp(i % 2, 8 + i, 4095, 1'b1);
            next();
        end
        drive_job('{opcode: 12'h0FF, ct: 1'b0, slot: 4'd15});
        @(negedge CLK);
        check("s2_full", 32'({job_ready, busy}), 32'({1'b0, 1'b1}));
        next();
        job_valid = 1'b0;
        wait_drain(20000);
        @(negedge CLK);
        check("s2_idle", 32'({busy, job_ready}), 32'({1'b0, 1'b1}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
